// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the sync_fifo family.
//   fifo_flags_t      : bundled status flags for consumers that pass status
//                       around as one value.
//   clog2             : ceiling log2 for elaboration-time width math.
//   level_width       : bits needed to count 0..depth inclusive.
//   af_thresh_legal   : legality of an almost-full threshold (1..depth).
//   ae_thresh_legal   : legality of an almost-empty threshold (0..depth-1).
// ---------------------------------------------------------------------------
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Occupancy runs 0..depth inclusive, so one more code point than depth.
    function automatic int level_width(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic bit af_thresh_legal(input int depth, input int thresh);
        return (thresh >= 1) && (thresh <= depth);
    endfunction

    function automatic bit ae_thresh_legal(input int depth, input int thresh);
        return (thresh >= 0) && (thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_if
// Handshake/data bundle between a FIFO user and sync_fifo.
//   master : drives flush, push, pop, in; observes out, level and flags.
//   slave  : the FIFO side of the same signals.
// ---------------------------------------------------------------------------
interface sync_fifo_if #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 32
);
    logic              flush;
    logic              push;
    logic              pop;
    logic [DWIDTH-1:0] in;
    logic [DWIDTH-1:0] out;
    logic [AWIDTH:0]   level;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, push, pop, in,
        input  out, level, full, empty, almost_full, almost_empty,
               overflow, underflow
    );

    modport slave (
        input  flush, push, pop, in,
        output out, level, full, empty, almost_full, almost_empty,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// ---------------------------------------------------------------------------
// sync_fifo_ram
// DEPTH x DWIDTH storage, one synchronous write port and one asynchronous
// read port. Contents are cleared by the asynchronous reset, so it is built
// from flops rather than a block RAM.
//   clk_i, rst_i : clock and asynchronous active-high reset
//   we, waddr, wdata : write port
//   raddr, rdata     : combinational read port
// ---------------------------------------------------------------------------
module sync_fifo_ram #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] mem_d [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        always_comb begin
            mem_d[gi] = mem_q[gi];
            if (we && (waddr == AWIDTH'(gi))) begin
                mem_d[gi] = wdata;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                mem_q[gi] <= '0;
            end else begin
                mem_q[gi] <= mem_d[gi];
            end
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO using all 2**AWIDTH entries.
// Holds pointers, occupancy level, status flags and optional error flags;
// storage lives in sync_fifo_ram.
//   clk_i : clock          rst_i : asynchronous active-high reset
//   bus   : sync_fifo_if.slave (flush/push/pop/in in; out/level/flags out)
// Optional feature macro: SYNC_FIFO_ERR_EN enables sticky overflow and
// underflow flags; without it both outputs are constant 0.
// ---------------------------------------------------------------------------
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int AWIDTH    = 4,
    parameter int DWIDTH    = 32,
    parameter int AF_THRESH = (1 << AWIDTH) - 4,
    parameter int AE_THRESH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    sync_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam int LW    = level_width(DEPTH);

    if (!af_thresh_legal(DEPTH, AF_THRESH)) begin : g_bad_af
        $error("sync_fifo: AF_THRESH out of range 1..DEPTH");
    end
    if (!ae_thresh_legal(DEPTH, AE_THRESH)) begin : g_bad_ae
        $error("sync_fifo: AE_THRESH out of range 0..DEPTH-1");
    end
    if (LW != AWIDTH + 1) begin : g_bad_lw
        $error("sync_fifo: level width does not match interface");
    end
    if ($bits(bus.in) != DWIDTH) begin : g_bad_dw
        $error("sync_fifo: interface DWIDTH differs from module DWIDTH");
    end

    logic [AWIDTH-1:0] widx_q, widx_d;
    logic [AWIDTH-1:0] ridx_q, ridx_d;
    logic [LW-1:0]     level_q, level_d;
    logic              pop_ok;
    logic              push_ok;
    logic              ram_we;
    logic              overflow;
    logic              underflow;
    fifo_flags_t       flags;

    // Flags decode straight from the registered level: no extra lag.
    always_comb begin
        flags              = '0;
        flags.full         = (level_q == LW'(DEPTH));
        flags.empty        = (level_q == '0);
        flags.almost_full  = (level_q >= LW'(AF_THRESH));
        flags.almost_empty = (level_q <= LW'(AE_THRESH));
        flags.overflow     = overflow;
        flags.underflow    = underflow;
    end

    // A push into a full FIFO is fine when a pop frees the head this cycle.
    always_comb begin
        pop_ok  = bus.pop && !flags.empty;
        push_ok = bus.push && (!flags.full || pop_ok);
        ram_we  = push_ok && !bus.flush;
        widx_d  = widx_q;
        ridx_d  = ridx_q;
        level_d = level_q;
        if (bus.flush) begin
            widx_d  = '0;
            ridx_d  = '0;
            level_d = '0;
        end else begin
            if (push_ok) widx_d = widx_q + AWIDTH'(1);
            if (pop_ok)  ridx_d = ridx_q + AWIDTH'(1);
            if (push_ok && !pop_ok) level_d = level_q + LW'(1);
            if (pop_ok && !push_ok) level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            widx_q  <= '0;
            ridx_q  <= '0;
            level_q <= '0;
        end else begin
            widx_q  <= widx_d;
            ridx_q  <= ridx_d;
            level_q <= level_d;
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky until flush; a flush cycle never sets them itself.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (bus.push && !push_ok)    overflow_d  = 1'b1;
            if (bus.pop && flags.empty)  underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    sync_fifo_ram #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_ram (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we    (ram_we),
        .waddr (widx_q),
        .wdata (bus.in),
        .raddr (ridx_q),
        .rdata (bus.out)
    );

    assign bus.level        = level_q;
    assign bus.full         = flags.full;
    assign bus.empty        = flags.empty;
    assign bus.almost_full  = flags.almost_full;
    assign bus.almost_empty = flags.almost_empty;
    assign bus.overflow     = flags.overflow;
    assign bus.underflow    = flags.underflow;
endmodule
